mode_display_scan: RTL

//  Downstream consumer of the debounced button mode counter (4-bit mode value 1..5).

---
 rtl/mode_display_scan_pkg.sv | 41 ++++
 rtl/mode_display_scan_if.sv | 19 +
 rtl/mode_display_scan_seg7_decode.sv | 11 +
 rtl/mode_display_scan.sv | 105 ++++++++++
 4 files changed

// File: rtl/mode_display_scan_pkg.sv
// mode_display_pkg: shared constants and the 4-bit value to 7-segment decode
// for the mode display scanner.
// Segment encoding is active-low, bit order {g,f,e,d,c,b,a}.
// Value 0 means "no mode yet" and decodes to blank.
// Values 10..15 are out of range for the upstream counter and decode to a dash.
package mode_display_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

    // Value 0 is blank, not SEG_0: an empty history slot must not light a "0".
    function automatic logic [SEG_W-1:0] decode(input logic [DIGIT_W-1:0] v);
        case (v)
            4'd0:    decode = SEG_BLANK;
            4'd1:    decode = SEG_1;
            4'd2:    decode = SEG_2;
            4'd3:    decode = SEG_3;
            4'd4:    decode = SEG_4;
            4'd5:    decode = SEG_5;
            4'd6:    decode = SEG_6;
            4'd7:    decode = SEG_7;
            4'd8:    decode = SEG_8;
            4'd9:    decode = SEG_9;
            default: decode = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/mode_display_scan_if.sv
// mode_display_scan_if: groups the mode input and the display outputs.
//   mode_in       4  mode value from the upstream counter
//   anode         8  active-low one-hot digit enable
//   seg_data      7  active-low segments {g,f,e,d,c,b,a}
//   mode_changed  1  one-cycle pulse on capture of a new mode
// Modports:
//   master: drives mode_in and observes the display.
//   slave:  used by the scanner.
interface mode_display_scan_if;
    import mode_display_pkg::*;

    logic [DIGIT_W-1:0] mode_in;
    logic [7:0]         anode;
    logic [SEG_W-1:0]   seg_data;
    logic               mode_changed;

    modport master (output mode_in, input anode, seg_data, mode_changed);
    modport slave  (input mode_in, output anode, seg_data, mode_changed);
endinterface

// File: rtl/mode_display_scan_seg7_decode.sv
// seg7_decode: combinational 4-bit value to active-low 7-segment pattern.
//   digit  in   4  value to show
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import mode_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);
    assign seg = decode(digit);
endmodule

// File: rtl/mode_display_scan.sv
// mode_display_scan: captures mode changes into a shift history and scans them
// onto a time-multiplexed active-low 7-segment display.
// Digit 0 shows the current mode, and digits 1..NUM_DIGITS-1 show older modes, newest first.
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   bus    mode_display_scan_if.slave (mode_in, anode, seg_data, mode_changed)
// Optional feature macro: BLINK_ON_CHANGE_EN.
//   When it is defined, digit 0 blinks for BLINK_TICKS scan frames after each capture.
module mode_display_scan
    import mode_display_pkg::*;
#(
    parameter int REFRESH_DIV = 17,
    parameter int NUM_DIGITS  = 4,
    parameter int BLINK_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mode_display_scan_if.slave   bus
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_TICKS < 1) begin : g_bad_param
        $error("mode_display_scan: parameter out of range");
    end

    logic [REFRESH_DIV-1:0] prescaler;
    logic [2:0]             idx;
    logic [DIGIT_W-1:0]     cur;
    logic [DIGIT_W-1:0]     hist [1:7];
    logic [DIGIT_W-1:0]     sel;
    logic [SEG_W-1:0]       seg_dec;
    logic                   tick, last, capture, blank0;

    assign tick    = &prescaler;
    assign last    = (idx == 3'(NUM_DIGITS - 1));
    assign capture = (bus.mode_in != cur);

    // Scan timing: one digit per 2^REFRESH_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick)
                idx <= last ? 3'd0 : idx + 3'd1;
        end
    end

    // Capture and history shift.
    // Every change is taken, including back-to-back changes.
    // All seven history slots shift; only those below NUM_DIGITS are ever shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
            for (int k = 1; k < 8; k++) hist[k] <= '0;
        end else if (capture) begin
            cur     <= bus.mode_in;
            hist[1] <= cur;
            for (int k = 2; k < 8; k++) hist[k] <= hist[k-1];
        end
    end

    always_comb begin
        sel = cur;
        for (int k = 1; k < 8; k++)
            if (idx == 3'(k)) sel = hist[k];
    end

    seg7_decode u_dec (.digit(sel), .seg(seg_dec));

`ifdef BLINK_ON_CHANGE_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);
    logic [BW-1:0] blink_cnt;

    // A capture reloads the count, even mid-blink.
    // The count otherwise drops once per completed frame.
    always_ff @(posedge clk) begin
        if (reset)
            blink_cnt <= '0;
        else if (capture)
            blink_cnt <= BW'(BLINK_TICKS);
        else if (tick && last && blink_cnt != '0)
            blink_cnt <= blink_cnt - 1'b1;
    end

    assign blank0 = blink_cnt[0];
`else
    assign blank0 = 1'b0;
`endif

    // Registered outputs.
    // These follow idx/cur/hist with one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.anode        <= 8'hFF;
            bus.seg_data     <= SEG_BLANK;
            bus.mode_changed <= 1'b0;
        end else begin
            bus.anode        <= ~(8'b1 << idx);
            bus.seg_data     <= (idx == 3'd0 && blank0) ? SEG_BLANK : seg_dec;
            bus.mode_changed <= capture;
        end
    end

endmodule
